// File: rtl/fwd_pkg.sv
// Shared types and defaults for the EX forwarding / ID hazard unit.
package fwd_pkg;

    localparam int unsigned NUM_SRC_DEF  = 2;
    localparam int unsigned NUM_STG_DEF  = 2;
    localparam int unsigned REG_AW_DEF   = 5;
    localparam int unsigned MC_DEPTH_DEF = 4;
    localparam int unsigned STALL_W      = 32;

    // Forwarding select encoding: 0 reads the register file, k selects stage k-1
    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        FWD_STG0 = 2'd1,
        FWD_STG1 = 2'd2
    } fwd_sel_e;

    // Reason ID is held, highest-priority cause first
    typedef enum logic [2:0] {
        HZ_NONE     = 3'd0,
        HZ_LOAD_USE = 3'd1,
        HZ_RAW_BUSY = 3'd2,
        HZ_WAW_BUSY = 3'd3,
        HZ_MC_FULL  = 3'd4
    } hz_cause_e;

    // Collapse the individual hazard flags into a single cause
    function automatic hz_cause_e hz_cause(input logic load_use, input logic raw_busy,
                                           input logic waw_busy, input logic mc_full);
        hz_cause_e c;
        c = HZ_NONE;
        if (mc_full)  c = HZ_MC_FULL;
        if (waw_busy) c = HZ_WAW_BUSY;
        if (raw_busy) c = HZ_RAW_BUSY;
        if (load_use) c = HZ_LOAD_USE;
        return c;
    endfunction

endpackage

// File: rtl/fwd_scoreboard.sv
// Busy-register scoreboard and outstanding-op counter for multi-cycle ops.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int unsigned NUM_SRC  = NUM_SRC_DEF,
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned MC_DEPTH = MC_DEPTH_DEF,
    parameter int unsigned CNT_W    = $clog2(MC_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           issue_i,
    input  logic [REG_AW-1:0]              issue_dst_i,
    input  logic                           done_i,
    input  logic [REG_AW-1:0]              done_dst_i,
    input  logic                           kill_i,
    input  logic [NUM_SRC-1:0][REG_AW-1:0] rd_src_i,
    input  logic [NUM_SRC-1:0]             rd_used_i,
    input  logic                           wr_en_i,
    input  logic [REG_AW-1:0]              wr_dst_i,
    output logic                           raw_busy_o,
    output logic                           waw_busy_o,
    output logic                           full_o,
    output logic [CNT_W-1:0]               count_o
);

    localparam int unsigned NUM_REG = 1 << REG_AW;

    logic [NUM_REG-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Next scoreboard state: clear on done, then set on issue; kill wipes everything
    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        if (done_i) begin
            busy_d[done_dst_i] = 1'b0;
            if (count_q != '0) begin
                count_d = count_d - CNT_W'(1);
            end
        end
        if (issue_i) begin
            count_d = count_d + CNT_W'(1);
            if (issue_dst_i != '0) begin
                busy_d[issue_dst_i] = 1'b1;
            end
        end
        if (kill_i) begin
            busy_d  = '0;
            count_d = '0;
        end
    end

    // Scoreboard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // Lookups against the pending destinations
    always_comb begin
        raw_busy_o = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rd_used_i[i] && (rd_src_i[i] != '0) && busy_q[rd_src_i[i]]) begin
                raw_busy_o = 1'b1;
            end
        end
        waw_busy_o = wr_en_i && (wr_dst_i != '0) && busy_q[wr_dst_i];
        full_o     = (count_q == CNT_W'(MC_DEPTH));
    end

    assign count_o = count_q;

    // A completion with nothing outstanding points at a broken multi-cycle unit
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (done_i && !kill_i) |-> (count_q != '0));

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding selects plus ID stall generation and stall statistics.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned NUM_SRC  = NUM_SRC_DEF,
    parameter int unsigned NUM_STG  = NUM_STG_DEF,
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned MC_DEPTH = MC_DEPTH_DEF,
    parameter int unsigned SEL_W    = $clog2(NUM_STG + 1),
    parameter int unsigned CNT_W    = $clog2(MC_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC-1:0][REG_AW-1:0] ex_src_i,
    input  logic [NUM_STG-1:0][REG_AW-1:0] stg_dst_i,
    input  logic [NUM_STG-1:0]             stg_wb_i,
    output logic [NUM_SRC-1:0][SEL_W-1:0]  fwd_sel_o,
    input  logic                           id_valid_i,
    input  logic [NUM_SRC-1:0][REG_AW-1:0] id_src_i,
    input  logic [NUM_SRC-1:0]             id_src_used_i,
    input  logic [REG_AW-1:0]              id_dst_i,
    input  logic                           id_wb_i,
    input  logic                           id_is_mc_i,
    input  logic                           ex_is_load_i,
    input  logic [REG_AW-1:0]              ex_dst_i,
    input  logic                           mc_done_i,
    input  logic [REG_AW-1:0]              mc_done_dst_i,
    input  logic                           mc_kill_i,
    output logic                           stall_id_o,
    output logic                           mc_issue_o,
    output logic [CNT_W-1:0]               mc_outstanding_o,
    output logic [STALL_W-1:0]             stall_cycles_o
);

    logic               load_use;
    logic               raw_busy;
    logic               waw_busy;
    logic               mc_full;
    logic               sb_raw;
    logic               sb_waw;
    logic               sb_full;
    hz_cause_e          cause;
    logic [STALL_W-1:0] stall_cycles_q, stall_cycles_d;

    // Forwarding priority: scan oldest to youngest so the youngest match wins
    always_comb begin
        fwd_sel_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_sel_o[i] = SEL_W'(FWD_RF);
            for (int k = NUM_STG - 1; k >= 0; k--) begin
                if (stg_wb_i[k] && (stg_dst_i[k] != '0) && (stg_dst_i[k] == ex_src_i[i])) begin
                    fwd_sel_o[i] = SEL_W'(k + 1);
                end
            end
        end
    end

    // Load-use: a used ID source needs the value the EX load has not fetched yet
    always_comb begin
        load_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used_i[i] && (id_src_i[i] == ex_dst_i)) begin
                load_use = 1'b1;
            end
        end
        load_use = load_use && id_valid_i && ex_is_load_i && (ex_dst_i != '0);
    end

    fwd_scoreboard #(
        .NUM_SRC  (NUM_SRC),
        .REG_AW   (REG_AW),
        .MC_DEPTH (MC_DEPTH),
        .CNT_W    (CNT_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_i     (mc_issue_o),
        .issue_dst_i (id_dst_i),
        .done_i      (mc_done_i),
        .done_dst_i  (mc_done_dst_i),
        .kill_i      (mc_kill_i),
        .rd_src_i    (id_src_i),
        .rd_used_i   (id_src_used_i),
        .wr_en_i     (id_wb_i),
        .wr_dst_i    (id_dst_i),
        .raw_busy_o  (sb_raw),
        .waw_busy_o  (sb_waw),
        .full_o      (sb_full),
        .count_o     (mc_outstanding_o)
    );

    // Stall combine and multi-cycle issue acceptance
    always_comb begin
        raw_busy   = id_valid_i && sb_raw;
        waw_busy   = id_valid_i && sb_waw;
        mc_full    = id_valid_i && id_is_mc_i && sb_full;
        cause      = hz_cause(load_use, raw_busy, waw_busy, mc_full);
        stall_id_o = (cause != HZ_NONE);
        mc_issue_o = id_valid_i && id_is_mc_i && !stall_id_o && !mc_kill_i;
    end

    // Saturating count of stalled cycles
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_id_o && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + STALL_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: vector table, directed sequences, random vs model.
module tb_fwd_hazard_unit;

    logic             clk;
    logic             rst_n;
    logic [1:0][4:0]  ex_src;
    logic [1:0][4:0]  stg_dst;
    logic [1:0]       stg_wb;
    logic [1:0][1:0]  fwd_sel;
    logic             id_valid;
    logic [1:0][4:0]  id_src;
    logic [1:0]       id_src_used;
    logic [4:0]       id_dst;
    logic             id_wb;
    logic             id_is_mc;
    logic             ex_is_load;
    logic [4:0]       ex_dst;
    logic             mc_done;
    logic [4:0]       mc_done_dst;
    logic             mc_kill;
    logic             stall_id;
    logic             mc_issue;
    logic [2:0]       mc_outstanding;
    logic [31:0]      stall_cycles;

    fwd_hazard_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_src_i         (ex_src),
        .stg_dst_i        (stg_dst),
        .stg_wb_i         (stg_wb),
        .fwd_sel_o        (fwd_sel),
        .id_valid_i       (id_valid),
        .id_src_i         (id_src),
        .id_src_used_i    (id_src_used),
        .id_dst_i         (id_dst),
        .id_wb_i          (id_wb),
        .id_is_mc_i       (id_is_mc),
        .ex_is_load_i     (ex_is_load),
        .ex_dst_i         (ex_dst),
        .mc_done_i        (mc_done),
        .mc_done_dst_i    (mc_done_dst),
        .mc_kill_i        (mc_kill),
        .stall_id_o       (stall_id),
        .mc_issue_o       (mc_issue),
        .mc_outstanding_o (mc_outstanding),
        .stall_cycles_o   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          busy_m [32];
    int          cnt_m;
    longint      stalls_m;

    // Values sampled from the DUT in the last cycle() call
    int s_sel0, s_sel1, s_stall, s_issue, s_cnt;
    longint s_cyc;

    typedef struct {
        logic [4:0] xs0, xs1, sd0, sd1;
        logic [1:0] wb;
        logic       idv;
        logic [4:0] is0, is1;
        logic [1:0] used;
        logic       ld;
        logic [4:0] exd;
        int         e_sel0, e_sel1;
        int         e_stall;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_fwd(input logic [4:0] src);
        for (int k = 0; k < 2; k++) begin
            if (stg_wb[k] && stg_dst[k] != 5'd0 && stg_dst[k] == src) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit m_reads(input logic [4:0] r);
        return (id_src_used[0] && id_src[0] == r) || (id_src_used[1] && id_src[1] == r);
    endfunction

    function automatic bit m_stall();
        bit lu, raw, waw, full;
        lu   = ex_is_load && ex_dst != 5'd0 && m_reads(ex_dst);
        raw  = (id_src_used[0] && id_src[0] != 5'd0 && busy_m[id_src[0]]) ||
               (id_src_used[1] && id_src[1] != 5'd0 && busy_m[id_src[1]]);
        waw  = id_wb && id_dst != 5'd0 && busy_m[id_dst];
        full = id_is_mc && cnt_m == 4;
        return id_valid && (lu || raw || waw || full);
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
        cnt_m    = 0;
        stalls_m = 0;
    endtask

    task automatic idle();
        ex_src = '0; stg_dst = '0; stg_wb = '0;
        id_valid = 0; id_src = '0; id_src_used = '0; id_dst = '0; id_wb = 0; id_is_mc = 0;
        ex_is_load = 0; ex_dst = '0; mc_done = 0; mc_done_dst = '0; mc_kill = 0;
    endtask

    // One clock: check outputs against the model, then advance the model at the edge
    task automatic cycle();
        bit st, iss;
        #2;
        st  = m_stall();
        iss = id_valid && id_is_mc && !st && !mc_kill;
        s_sel0 = int'(fwd_sel[0]); s_sel1 = int'(fwd_sel[1]);
        s_stall = int'(stall_id); s_issue = int'(mc_issue);
        s_cnt = int'(mc_outstanding); s_cyc = longint'(stall_cycles);
        chk("fwd_sel0", s_sel0, m_fwd(ex_src[0]));
        chk("fwd_sel1", s_sel1, m_fwd(ex_src[1]));
        chk("stall_id", s_stall, st);
        chk("mc_issue", s_issue, iss);
        chk("mc_outstanding", s_cnt, cnt_m);
        chk("stall_cycles", s_cyc, stalls_m);
        @(posedge clk);
        if (mc_kill) begin
            for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
            cnt_m = 0;
        end else begin
            if (mc_done) begin
                busy_m[mc_done_dst] = 1'b0;
                if (cnt_m > 0) cnt_m--;
            end
            if (iss) begin
                cnt_m++;
                if (id_dst != 5'd0) busy_m[id_dst] = 1'b1;
            end
        end
        if (st && stalls_m != 64'hFFFF_FFFF) stalls_m++;
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic mc_op(input logic [4:0] dst);
        idle();
        id_valid = 1; id_is_mc = 1; id_wb = 1; id_dst = dst;
    endtask

    task automatic rd_op(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
        idle();
        id_valid = 1; id_src[0] = s0; id_src[1] = s1; id_src_used = used;
    endtask

    initial begin
        tbl[0] = '{5'd5, 5'd3, 5'd5, 5'd5, 2'b11, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1, 0, 0};
        tbl[1] = '{5'd5, 5'd3, 5'd5, 5'd5, 2'b10, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2, 0, 0};
        tbl[2] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 0, 0, 0};
        tbl[3] = '{5'd6, 5'd4, 5'd4, 5'd6, 2'b11, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2, 1, 0};
        tbl[4] = '{5'd5, 5'd5, 5'd5, 5'd5, 2'b00, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 0, 0, 0};
        tbl[5] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 5'd2, 5'd7, 2'b11, 1'b1, 5'd7, 0, 0, 1};
        tbl[6] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 5'd2, 5'd7, 2'b01, 1'b1, 5'd7, 0, 0, 0};
        tbl[7] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd0, 0, 0, 0};
        tbl[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd2, 5'd7, 2'b11, 1'b1, 5'd7, 0, 0, 0};
        tbl[9] = '{5'd9, 5'd9, 5'd9, 5'd9, 2'b01, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1, 1, 0};

        idle();
        rst_n = 1'b0;
        model_clear();
        #12;
        rst_n = 1'b1;
        #1;

        // Reset state
        cycle();
        chk("rst_outstanding", s_cnt, 0);
        chk("rst_stall_cycles", s_cyc, 0);
        chk("rst_stall_id", s_stall, 0);
        chk("rst_mc_issue", s_issue, 0);

        // Combinational vector table
        for (int v = 0; v < 10; v++) begin
            idle();
            ex_src[0] = tbl[v].xs0; ex_src[1] = tbl[v].xs1;
            stg_dst[0] = tbl[v].sd0; stg_dst[1] = tbl[v].sd1; stg_wb = tbl[v].wb;
            id_valid = tbl[v].idv; id_src[0] = tbl[v].is0; id_src[1] = tbl[v].is1;
            id_src_used = tbl[v].used; ex_is_load = tbl[v].ld; ex_dst = tbl[v].exd;
            cycle();
            chk($sformatf("tbl%0d_sel0", v), s_sel0, tbl[v].e_sel0);
            chk($sformatf("tbl%0d_sel1", v), s_sel1, tbl[v].e_sel1);
            chk($sformatf("tbl%0d_stall", v), s_stall, tbl[v].e_stall);
        end

        // RAW on a multi-cycle destination, held through the done cycle
        do_reset();
        mc_op(5'd9); cycle();
        chk("raw_issue", s_issue, 1);
        rd_op(5'd9, 5'd0, 2'b01); cycle();
        chk("raw_cnt1", s_cnt, 1);
        chk("raw_stall_a", s_stall, 1);
        cycle();
        chk("raw_stall_b", s_stall, 1);
        mc_done = 1; mc_done_dst = 5'd9; cycle();
        chk("raw_stall_done", s_stall, 1);
        mc_done = 0; cycle();
        chk("raw_stall_after", s_stall, 0);
        chk("raw_cnt0", s_cnt, 0);
        chk("raw_stall_cycles", s_cyc, 3);

        // Capacity limit and concurrent done/issue
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            mc_op(5'(r)); cycle();
            chk("cap_issue", s_issue, 1);
        end
        mc_op(5'd5); cycle();
        chk("cap_full_stall", s_stall, 1);
        chk("cap_full_issue", s_issue, 0);
        chk("cap_full_cnt", s_cnt, 4);
        mc_done = 1; mc_done_dst = 5'd2; cycle();
        chk("cap_done_stall", s_stall, 1);
        mc_op(5'd6); cycle();
        chk("cap_x6_issue", s_issue, 1);
        chk("cap_x6_cnt", s_cnt, 3);
        idle(); mc_done = 1; mc_done_dst = 5'd3; cycle();
        chk("cap_back4", s_cnt, 4);
        mc_op(5'd7); mc_done = 1; mc_done_dst = 5'd4; cycle();
        chk("cap_same_issue", s_issue, 1);
        chk("cap_same_cnt", s_cnt, 3);
        rd_op(5'd4, 5'd3, 2'b11); cycle();
        chk("cap_cnt_hold", s_cnt, 3);
        chk("cap_cleared_rd", s_stall, 0);
        rd_op(5'd0, 5'd7, 2'b10); cycle();
        chk("cap_new_busy", s_stall, 1);

        // Kill, then asynchronous reset during a stall
        do_reset();
        for (int r = 10; r <= 12; r++) begin
            mc_op(5'(r)); cycle();
        end
        mc_op(5'd14); id_wb = 0; mc_kill = 1; mc_done = 1; mc_done_dst = 5'd10; cycle();
        chk("kill_cnt_before", s_cnt, 3);
        chk("kill_blocks_issue", s_issue, 0);
        rd_op(5'd10, 5'd11, 2'b11); cycle();
        chk("kill_cnt0", s_cnt, 0);
        chk("kill_no_stall", s_stall, 0);
        mc_op(5'd13); cycle();
        rd_op(5'd13, 5'd0, 2'b01); cycle();
        cycle();
        #2;
        chk("pre_rst_stall", stall_id, 1);
        chk("pre_rst_cycles", stall_cycles, 2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_stall", stall_id, 0);
        chk("async_rst_cnt", mc_outstanding, 0);
        chk("async_rst_cycles", stall_cycles, 0);
        model_clear();
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;

        // WAW and register 0
        do_reset();
        mc_op(5'd3); cycle();
        idle(); id_valid = 1; id_wb = 1; id_dst = 5'd3; cycle();
        chk("waw_stall", s_stall, 1);
        mc_op(5'd0); cycle();
        chk("x0_issue", s_issue, 1);
        chk("x0_cnt_before", s_cnt, 1);
        rd_op(5'd0, 5'd0, 2'b11); cycle();
        chk("x0_no_busy", s_stall, 0);
        chk("x0_cnt", s_cnt, 2);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            ex_src[0]   = 5'($urandom_range(0, 7));
            ex_src[1]   = 5'($urandom_range(0, 7));
            stg_dst[0]  = 5'($urandom_range(0, 7));
            stg_dst[1]  = 5'($urandom_range(0, 7));
            stg_wb      = 2'($urandom_range(0, 3));
            id_valid    = ($urandom_range(0, 3) != 0);
            id_src[0]   = 5'($urandom_range(0, 7));
            id_src[1]   = 5'($urandom_range(0, 7));
            id_src_used = 2'($urandom_range(0, 3));
            id_dst      = 5'($urandom_range(0, 7));
            id_wb       = ($urandom_range(0, 1) != 0);
            id_is_mc    = ($urandom_range(0, 2) == 0);
            ex_is_load  = ($urandom_range(0, 3) == 0);
            ex_dst      = 5'($urandom_range(0, 7));
            mc_kill     = ($urandom_range(0, 31) == 0);
            mc_done     = (cnt_m > 0) && ($urandom_range(0, 2) == 0);
            mc_done_dst = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor of the EX-stage forwarding unit, covering both operand forwarding and stall generation.
- Forwarding mux selects for NUM_SRC EX operands across NUM_STG downstream writeback stages, youngest stage first.
- ID-stage stall generation for load-use hazards and for a register scoreboard of outstanding multi-cycle ops (mul/div).
- Sits between ID/EX decode and the pipeline control; drives EX operand muxes and the IF/ID stall/bubble controls.

Parameters:
- NUM_SRC, 2, source operands per instruction.
- NUM_STG, 2, forwarding stages; index 0 = EX/MEM (youngest), NUM_STG-1 = oldest.
- REG_AW, 5, register address width; 2**REG_AW architectural registers.
- MC_DEPTH, 4, max outstanding multi-cycle ops (1..2**REG_AW-1).
- SEL_W, $clog2(NUM_STG+1), width of each forwarding select.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_src  in  NUM_SRC x REG_AW  EX-stage source registers.
- stg_dst  in  NUM_STG x REG_AW  destination register per forwarding stage.
- stg_wb  in  NUM_STG  writeback enable per stage.
- fwd_sel  out  NUM_SRC x SEL_W  0 = register file, k = stage k-1.
- id_valid  in  1  ID holds a valid instruction.
- id_src  in  NUM_SRC x REG_AW  ID-stage source registers.
- id_src_used  in  NUM_SRC  source actually read.
- id_dst  in  REG_AW  ID destination.
- id_wb  in  1  ID instruction writes id_dst.
- id_is_mc  in  1  ID instruction is multi-cycle.
- ex_is_load  in  1  EX instruction is a load; its destination is stg_dst[0]'s predecessor, given on ex_dst.
- ex_dst  in  REG_AW  EX-stage destination.
- mc_done  in  1  multi-cycle unit completes this cycle.
- mc_done_dst  in  REG_AW  completing destination.
- mc_kill  in  1  multi-cycle unit aborted; all pending ops discarded.
- stall_id  out  1  hold PC and IF/ID, insert bubble into ID/EX.
- mc_issue  out  1  multi-cycle op accepted this cycle.
- mc_outstanding  out  $clog2(MC_DEPTH+1)  pending op count.
- stall_cycles  out  32  saturating stall counter.

Behaviour:
- Reset values: busy vector 0, mc_outstanding 0, stall_cycles 0. Consequently stall_id = 0 and mc_issue = 0, and fwd_sel follows its inputs.
- fwd_sel (combinational, per source i):
  - Equals the lowest k for which stg_wb[k] && stg_dst[k] != 0 && stg_dst[k] == ex_src[i]; value k+1.
  - Otherwise 0.
  - Register 0 never forwards.
- Hazards (combinational; each qualified by id_valid):
  - load_use: ex_is_load && ex_dst != 0 && some used id_src == ex_dst.
  - raw_busy: some used id_src != 0 with busy[id_src] set.
  - waw_busy: id_wb && id_dst != 0 && busy[id_dst].
  - mc_full: id_is_mc && mc_outstanding == MC_DEPTH.
- stall_id = OR of all four hazards.
- mc_issue = id_valid && id_is_mc && !stall_id && !mc_kill.
- Scoreboard (registered, async clear):
  - mc_done clears busy[mc_done_dst] and decrements the count.
  - mc_issue with id_dst != 0 sets busy[id_dst] and increments the count.
  - Same cycle, different registers: both take effect; the count is unchanged.
  - Same register in the same cycle is impossible, because waw_busy stalls the issue; the design still applies the clear first and the set wins.
  - mc_issue with id_dst == 0 still counts an outstanding op, but no busy bit is set.
  - Count underflow, i.e. mc_done at count 0, is ignored. An SVA assertion flags it.
  - mc_done on a non-busy register: count decrements, busy is unchanged.
- Busy bits clear on the edge after mc_done, so raw_busy holds through the done cycle. The register-file write lands that cycle, and the read in the next cycle sees the new value.
- mc_kill: next edge clears all busy bits and sets the count to 0. mc_kill overrides mc_done and blocks mc_issue that cycle.
- stall_cycles increments on each edge where stall_id = 1, and saturates at 32'hFFFF_FFFF.
- Reset mid-operation clears everything immediately (asynchronous); in-flight ops are forgotten.

Decomposition:
- fwd_pkg:
  - REG_AW default.
  - fwd_sel_e encoding constants (FWD_RF = 0).
  - Hazard-cause enum for debug.
- Sub-module fwd_scoreboard holds:
  - the busy vector,
  - the outstanding counter,
  - the kill/issue/done update,
  - raw/waw lookups.
- The top level holds forwarding priority, load-use detection, stall combine and the stall counter.

Test Plan:
- Forwarding priority: stg_dst = {5,5}, stg_wb = 2'b11, ex_src[0] = 5 -> fwd_sel[0] = 1; clear stg_wb[0] -> fwd_sel[0] = 2; ex_src = 0 with stg_dst = 0 -> 0.
- Load-use: ex_is_load = 1, ex_dst = 7, id_src[1] = 7 used -> stall_id = 1 for exactly that cycle; id_src_used[1] = 0 -> stall_id = 0.
- Scoreboard RAW: issue mc to x9 -> busy, mc_outstanding = 1; ID reads x9 -> stall until mc_done_dst = 9 and one cycle after; stall_cycles counts every stalled edge.
- Capacity: issue MC_DEPTH = 4 ops to x1..x4, then a fifth mc -> stall_id = 1, mc_issue = 0; mc_done x2 with fifth issue to x6 in the following cycle -> count stays 4.
- Kill and reset: 3 outstanding, mc_kill -> next cycle count 0, all stalls drop; rst_n low mid-stall -> outputs and stall_cycles at 0 immediately.
- WAW and x0: busy x3, ID writes x3 -> stall; ID mc writing x0 -> no busy bit, count increments.
